// File: rtl/alu_ex_stage.sv
// alu_ex_stage
// Execute stage of the pipelined MIPS core. It takes the decoded ALU operation
// (MIPS func encoding), operands, destination and PC from the ID/EX boundary.
// It computes the result combinationally and captures it in the EX/MEM
// register, which honours stall and flush. Signed overflow on ADD/ADDI/SUB
// raises a one-cycle precise exception pulse toward COP0.
//
// Ports
//   i_clk, i_rst       clock (rising edge), synchronous active-high reset
//   i_valid            ID/EX slot holds a real instruction
//   i_aluControl[5:0]  operation code (MIPS func encoding)
//   i_ALUSrc_op1       1: shift amount from i_shamt, 0: from i_op1[4:0]
//   i_shamt[4:0]       instruction shamt field
//   i_op1, i_op2       rs value, rt value / extended immediate
//   i_rd[4:0]          destination register
//   i_reg_write        instruction writes the register file
//   i_pc               PC of the instruction
//   i_stall, i_flush   hold / kill the EX/MEM register
//   o_valid            EX/MEM slot valid
//   o_result, o_zero   registered result and (result == 0)
//   o_rd, o_pc         registered destination and PC
//   o_reg_write        registered write enable, cleared on overflow
//   o_ovf_exc          one-cycle overflow exception pulse
//   o_exc_pc           PC of the last faulting instruction
module alu_ex_stage #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [5:0]        i_aluControl,
  input  logic              i_ALUSrc_op1,
  input  logic [4:0]        i_shamt,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic [4:0]        i_rd,
  input  logic              i_reg_write,
  input  logic [DATA_W-1:0] i_pc,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic [4:0]        o_rd,
  output logic              o_reg_write,
  output logic [DATA_W-1:0] o_pc,
  output logic              o_ovf_exc,
  output logic [DATA_W-1:0] o_exc_pc
);

  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_ADDU  = 6'b100001;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SUBU  = 6'b100011;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_SLLV  = 6'b000100;
  localparam logic [5:0] OP_SRLV  = 6'b000110;
  localparam logic [5:0] OP_SRAV  = 6'b000111;
  localparam logic [5:0] OP_LUI   = 6'b111100;
  localparam logic [5:0] OP_ROTR  = 6'b111110;
  localparam logic [5:0] OP_ROTRV = 6'b111111;

  localparam int MSB = DATA_W - 1;

  logic [4:0]        sa;
  logic [4:0]        sa_neg;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] rot;
  logic              add_ovf;
  logic              sub_ovf;
  logic              slt;
  logic              sltu;
  logic [DATA_W-1:0] alu_result;
  logic              ovf;

  // Immediate-form shifts take the shamt field; variable forms take rs[4:0].
  assign sa     = i_ALUSrc_op1 ? i_shamt : i_op1[4:0];
  // Left part of the rotate shifts by (width - sa) mod width, so sa=0 leaves
  // i_op2 unchanged instead of shifting everything out.
  assign sa_neg = 5'd0 - sa;
  assign rot    = (i_op2 >> sa) | (i_op2 << sa_neg);

  assign sum  = i_op1 + i_op2;
  assign diff = i_op1 - i_op2;

  assign add_ovf = (i_op1[MSB] == i_op2[MSB]) && (sum[MSB]  != i_op1[MSB]);
  assign sub_ovf = (i_op1[MSB] != i_op2[MSB]) && (diff[MSB] != i_op1[MSB]);

  assign slt  = $signed(i_op1) < $signed(i_op2);
  assign sltu = i_op1 < i_op2;

  always_comb begin
    alu_result = '0;
    ovf        = 1'b0;
    case (i_aluControl)
      OP_ADD: begin
        alu_result = sum;
        ovf        = add_ovf;
      end
      OP_ADDU:  alu_result = sum;
      OP_SUB: begin
        alu_result = diff;
        ovf        = sub_ovf;
      end
      OP_SUBU:  alu_result = diff;
      OP_AND:   alu_result = i_op1 & i_op2;
      OP_OR:    alu_result = i_op1 | i_op2;
      OP_XOR:   alu_result = i_op1 ^ i_op2;
      OP_NOR:   alu_result = ~(i_op1 | i_op2);
      OP_SLT:   alu_result = {{(DATA_W-1){1'b0}}, slt};
      OP_SLTU:  alu_result = {{(DATA_W-1){1'b0}}, sltu};
      OP_SLL,
      OP_SLLV:  alu_result = i_op2 << sa;
      OP_SRL,
      OP_SRLV:  alu_result = i_op2 >> sa;
      OP_SRA,
      OP_SRAV:  alu_result = $signed(i_op2) >>> sa;
      OP_LUI:   alu_result = {i_op2[15:0], {(DATA_W-16){1'b0}}};
      OP_ROTR,
      OP_ROTRV: alu_result = rot;
      // Unknown funcs are trapped upstream; here they just produce zero.
      default: begin
        alu_result = '0;
        ovf        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_zero      <= 1'b0;
      o_rd        <= '0;
      o_reg_write <= 1'b0;
      o_pc        <= RESET_PC;
      o_ovf_exc   <= 1'b0;
      o_exc_pc    <= RESET_PC;
    end else if (i_flush) begin
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
      o_ovf_exc   <= 1'b0;
    end else if (i_stall) begin
      // A held instruction must not re-raise its exception.
      o_ovf_exc <= 1'b0;
    end else begin
      o_valid     <= i_valid;
      o_result    <= alu_result;
      o_zero      <= (alu_result == '0);
      o_rd        <= i_rd;
      o_pc        <= i_pc;
      o_reg_write <= i_valid & i_reg_write & ~ovf;
      o_ovf_exc   <= i_valid & ovf;
      if (i_valid && ovf) begin
        o_exc_pc <= i_pc;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
module tb_alu_ex_stage;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [5:0]  i_aluControl;
  logic        i_ALUSrc_op1;
  logic [4:0]  i_shamt;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic [31:0] i_pc;
  logic        i_stall;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic [31:0] o_pc;
  logic        o_ovf_exc;
  logic [31:0] o_exc_pc;

  int checks = 0;
  int errors = 0;

  // Reference view of the EX/MEM register.
  logic        m_valid;
  logic [31:0] m_result;
  logic        m_zero;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic [31:0] m_pc;
  logic        m_ovf;
  logic [31:0] m_exc_pc;

  localparam logic [5:0] ADD = 6'b100000, ADDU = 6'b100001, SUB = 6'b100010, SUBU = 6'b100011;
  localparam logic [5:0] AND_ = 6'b100100, OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111;
  localparam logic [5:0] SLT = 6'b101010, SLTU = 6'b101011, SLL = 6'b000000, SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011, SLLV = 6'b000100, SRLV = 6'b000110, SRAV = 6'b000111;
  localparam logic [5:0] LUI = 6'b111100, ROTR = 6'b111110, ROTRV = 6'b111111;

  logic [5:0] codes [20];

  alu_ex_stage #(.DATA_W(32), .RESET_PC(32'h0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_aluControl(i_aluControl),
    .i_ALUSrc_op1(i_ALUSrc_op1), .i_shamt(i_shamt), .i_op1(i_op1), .i_op2(i_op2),
    .i_rd(i_rd), .i_reg_write(i_reg_write), .i_pc(i_pc), .i_stall(i_stall),
    .i_flush(i_flush), .o_valid(o_valid), .o_result(o_result), .o_zero(o_zero),
    .o_rd(o_rd), .o_reg_write(o_reg_write), .o_pc(o_pc), .o_ovf_exc(o_ovf_exc),
    .o_exc_pc(o_exc_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural ALU: integer arithmetic, bit-at-a-time shifts and rotates.
  function automatic void model_alu(input logic [5:0] code, input logic src,
                                    input logic [4:0] shamt, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output bit ovf);
    int sa;
    longint s;
    sa  = src ? int'(shamt) : int'(a[4:0]);
    r   = 32'h0;
    ovf = 1'b0;
    case (code)
      ADD, ADDU: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = s[31:0];
        ovf = (code == ADD) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      SUB, SUBU: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = s[31:0];
        ovf = (code == SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      NOR_: r = ~(a | b);
      SLT:  r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      SLTU: r = (longint'({32'h0, a}) < longint'({32'h0, b})) ? 32'd1 : 32'd0;
      SLL, SLLV: begin r = b; repeat (sa) r = {r[30:0], 1'b0}; end
      SRL, SRLV: begin r = b; repeat (sa) r = {1'b0, r[31:1]}; end
      SRA, SRAV: begin r = b; repeat (sa) r = {r[31], r[31:1]}; end
      ROTR, ROTRV: begin r = b; repeat (sa) r = {r[0], r[31:1]}; end
      LUI: r = {b[15:0], 16'h0};
      default: r = 32'h0;
    endcase
  endfunction

  // Advance the model by one edge using the currently driven inputs, then
  // move to a safe sampling point just after the edge.
  task automatic tick();
    logic [31:0] r;
    bit ov;
    model_alu(i_aluControl, i_ALUSrc_op1, i_shamt, i_op1, i_op2, r, ov);
    if (i_rst) begin
      m_valid = 0; m_result = 0; m_zero = 0; m_rd = 0; m_rw = 0;
      m_pc = 0; m_ovf = 0; m_exc_pc = 0;
    end else if (i_flush) begin
      m_valid = 0; m_rw = 0; m_ovf = 0;
    end else if (i_stall) begin
      m_ovf = 0;
    end else begin
      m_valid  = i_valid;
      m_result = r;
      m_zero   = (r == 0);
      m_rd     = i_rd;
      m_pc     = i_pc;
      m_rw     = i_valid && i_reg_write && !ov;
      m_ovf    = i_valid && ov;
      if (i_valid && ov) m_exc_pc = i_pc;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] code, input logic src, input logic [4:0] shamt,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    i_valid = 1; i_aluControl = code; i_ALUSrc_op1 = src; i_shamt = shamt;
    i_op1 = a; i_op2 = b; i_pc = pc; i_rd = 5'd7; i_reg_write = 1;
    i_stall = 0; i_flush = 0; i_rst = 0;
  endtask

  task automatic test_reset();
    i_rst = 1; tick(); tick();
    checks++;
    if (o_valid !== 0 || o_result !== 0 || o_zero !== 0 || o_rd !== 0 || o_reg_write !== 0 ||
        o_pc !== 0 || o_ovf_exc !== 0 || o_exc_pc !== 0) begin
      errors++;
      $display("FAIL reset_init: valid=%b result=%h zero=%b rd=%0d rw=%b pc=%h ovf=%b exc_pc=%h expected all zero",
               o_valid, o_result, o_zero, o_rd, o_reg_write, o_pc, o_ovf_exc, o_exc_pc);
    end
    drive(ADD, 0, 0, 32'd5, 32'd7, 32'h40);
    tick();
    checks++;
    if (o_result !== 32'd12 || o_valid !== 1 || o_pc !== 32'h40) begin
      errors++;
      $display("FAIL add_before_reset: result=%h valid=%b pc=%h expected 0000000c 1 00000040", o_result, o_valid, o_pc);
    end
    i_rst = 1; tick();
    checks++;
    if (o_valid !== 0 || o_result !== 0 || o_zero !== 0 || o_rd !== 0 || o_reg_write !== 0 ||
        o_pc !== 0 || o_ovf_exc !== 0 || o_exc_pc !== 0) begin
      errors++;
      $display("FAIL reset_mid_op: valid=%b result=%h zero=%b rd=%0d rw=%b pc=%h ovf=%b exc_pc=%h expected all zero",
               o_valid, o_result, o_zero, o_rd, o_reg_write, o_pc, o_ovf_exc, o_exc_pc);
    end
    i_rst = 0;
  endtask

  task automatic test_arith();
    drive(ADDU, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h80);
    tick();
    checks++;
    if (o_result !== 0 || o_zero !== 1 || o_ovf_exc !== 0 || o_reg_write !== 1) begin
      errors++;
      $display("FAIL addu_wrap: result=%h zero=%b ovf=%b rw=%b expected 0 1 0 1", o_result, o_zero, o_ovf_exc, o_reg_write);
    end
    drive(ADD, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h100);
    tick();
    checks++;
    if (o_ovf_exc !== 1 || o_exc_pc !== 32'h100 || o_reg_write !== 0 || o_valid !== 1 || o_result !== 32'h80000000) begin
      errors++;
      $display("FAIL add_ovf: ovf=%b exc_pc=%h rw=%b valid=%b result=%h expected 1 100 0 1 80000000",
               o_ovf_exc, o_exc_pc, o_reg_write, o_valid, o_result);
    end
    drive(SUB, 0, 0, 32'h80000000, 32'h1, 32'h104);
    tick();
    checks++;
    if (o_ovf_exc !== 1 || o_exc_pc !== 32'h104 || o_result !== 32'h7FFFFFFF) begin
      errors++;
      $display("FAIL sub_ovf: ovf=%b exc_pc=%h result=%h expected 1 104 7fffffff", o_ovf_exc, o_exc_pc, o_result);
    end
    drive(SUB, 0, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h108);
    tick();
    checks++;
    if (o_ovf_exc !== 1 || o_exc_pc !== 32'h108 || o_reg_write !== 0) begin
      errors++;
      $display("FAIL sub_ovf_pos: ovf=%b exc_pc=%h rw=%b expected 1 108 0", o_ovf_exc, o_exc_pc, o_reg_write);
    end
    drive(ADDU, 0, 0, 32'h3, 32'h4, 32'h10C);
    tick();
    checks++;
    if (o_ovf_exc !== 0 || o_exc_pc !== 32'h108 || o_result !== 32'h7) begin
      errors++;
      $display("FAIL ovf_one_cycle: ovf=%b exc_pc=%h result=%h expected 0 108 7", o_ovf_exc, o_exc_pc, o_result);
    end
  endtask

  task automatic test_shift();
    drive(SRA, 1, 5'd4, 32'h0, 32'h80000000, 32'h200);
    tick();
    checks++;
    if (o_result !== 32'hF8000000) begin
      errors++;
      $display("FAIL sra_imm: result=%h expected f8000000", o_result);
    end
    drive(ROTRV, 0, 5'd0, 32'h8, 32'h12345678, 32'h204);
    tick();
    checks++;
    if (o_result !== 32'h78123456) begin
      errors++;
      $display("FAIL rotrv: result=%h expected 78123456", o_result);
    end
    drive(SLLV, 0, 5'd9, 32'h21, 32'h3, 32'h208);
    tick();
    checks++;
    if (o_result !== 32'h6) begin
      errors++;
      $display("FAIL sllv_mask: result=%h expected 00000006", o_result);
    end
    drive(ROTR, 1, 5'd0, 32'h5, 32'hCAFEF00D, 32'h20C);
    tick();
    checks++;
    if (o_result !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rotr_zero: result=%h expected cafef00d", o_result);
    end
    drive(SRL, 1, 5'd31, 32'h0, 32'h80000000, 32'h210);
    tick();
    checks++;
    if (o_result !== 32'h1) begin
      errors++;
      $display("FAIL srl_31: result=%h expected 00000001", o_result);
    end
  endtask

  task automatic test_compare_lui();
    drive(SLT, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h300);
    tick();
    checks++;
    if (o_result !== 32'h1 || o_zero !== 0) begin
      errors++;
      $display("FAIL slt: result=%h zero=%b expected 1 0", o_result, o_zero);
    end
    drive(SLTU, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h304);
    tick();
    checks++;
    if (o_result !== 32'h0 || o_zero !== 1) begin
      errors++;
      $display("FAIL sltu: result=%h zero=%b expected 0 1", o_result, o_zero);
    end
    drive(LUI, 0, 0, 32'h0, 32'h0000ABCD, 32'h308);
    tick();
    checks++;
    if (o_result !== 32'hABCD0000) begin
      errors++;
      $display("FAIL lui: result=%h expected abcd0000", o_result);
    end
    drive(6'b001000, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h30C);
    tick();
    checks++;
    if (o_result !== 0 || o_zero !== 1 || o_ovf_exc !== 0) begin
      errors++;
      $display("FAIL undefined_code: result=%h zero=%b ovf=%b expected 0 1 0", o_result, o_zero, o_ovf_exc);
    end
  endtask

  task automatic test_stall_flush();
    drive(SUB, 0, 0, 32'd9, 32'd9, 32'h400);
    tick();
    i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      i_aluControl = ADD; i_op1 = $urandom | 32'h1; i_op2 = $urandom; i_pc = $urandom;
      tick();
      checks++;
      if (o_result !== 0 || o_zero !== 1 || o_valid !== 1 || o_pc !== 32'h400) begin
        errors++;
        $display("FAIL stall_hold: cycle=%0d result=%h zero=%b valid=%b pc=%h expected 0 1 1 400",
                 k, o_result, o_zero, o_valid, o_pc);
      end
    end
    i_flush = 1;
    tick();
    checks++;
    if (o_valid !== 0 || o_reg_write !== 0 || o_ovf_exc !== 0) begin
      errors++;
      $display("FAIL stall_flush: valid=%b rw=%b ovf=%b expected 0 0 0", o_valid, o_reg_write, o_ovf_exc);
    end
    drive(ADD, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h500);
    i_stall = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (o_ovf_exc !== 0 || o_exc_pc !== 32'h108) begin
        errors++;
        $display("FAIL ovf_during_stall: cycle=%0d ovf=%b exc_pc=%h expected 0 108", k, o_ovf_exc, o_exc_pc);
      end
    end
    i_stall = 0;
    tick();
    checks++;
    if (o_ovf_exc !== 1 || o_exc_pc !== 32'h500 || o_valid !== 1 || o_reg_write !== 0) begin
      errors++;
      $display("FAIL ovf_after_stall: ovf=%b exc_pc=%h valid=%b rw=%b expected 1 500 1 0",
               o_ovf_exc, o_exc_pc, o_valid, o_reg_write);
    end
    i_stall = 1;
    tick();
    checks++;
    if (o_ovf_exc !== 0 || o_valid !== 1) begin
      errors++;
      $display("FAIL ovf_no_repeat: ovf=%b valid=%b expected 0 1", o_ovf_exc, o_valid);
    end
    i_stall = 0;
  endtask

  task automatic test_bubble();
    drive(ADD, 0, 0, 32'h80000000, 32'h80000000, 32'h600);
    i_valid = 0;
    tick();
    checks++;
    if (o_valid !== 0 || o_ovf_exc !== 0 || o_reg_write !== 0 || o_exc_pc !== 32'h500) begin
      errors++;
      $display("FAIL bubble: valid=%b ovf=%b rw=%b exc_pc=%h expected 0 0 0 500",
               o_valid, o_ovf_exc, o_reg_write, o_exc_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] edges [6];
    edges[0] = 32'h0; edges[1] = 32'h7FFFFFFF; edges[2] = 32'h80000000;
    edges[3] = 32'hFFFFFFFF; edges[4] = 32'h1; edges[5] = 32'h7FFFFFFE;
    for (int n = 0; n < 400; n++) begin
      i_rst        = ($urandom_range(0, 99) == 0);
      i_flush      = ($urandom_range(0, 15) == 0);
      i_stall      = ($urandom_range(0, 7) == 0);
      i_valid      = ($urandom_range(0, 5) != 0);
      i_aluControl = codes[$urandom_range(0, 19)];
      i_ALUSrc_op1 = 1'($urandom);
      i_shamt      = 5'($urandom);
      i_op1        = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      i_op2        = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      i_rd         = 5'($urandom);
      i_reg_write  = 1'($urandom);
      i_pc         = $urandom & 32'hFFFFFFFC;
      tick();
      checks++;
      if (o_valid !== m_valid || o_reg_write !== m_rw || o_ovf_exc !== m_ovf || o_exc_pc !== m_exc_pc) begin
        errors++;
        $display("FAIL rand_ctrl: n=%0d valid=%b/%b rw=%b/%b ovf=%b/%b exc_pc=%h/%h (got/expected)",
                 n, o_valid, m_valid, o_reg_write, m_rw, o_ovf_exc, m_ovf, o_exc_pc, m_exc_pc);
      end
      if (m_valid) begin
        checks++;
        if (o_result !== m_result || o_zero !== m_zero || o_rd !== m_rd || o_pc !== m_pc) begin
          errors++;
          $display("FAIL rand_data: n=%0d result=%h/%h zero=%b/%b rd=%0d/%0d pc=%h/%h (got/expected)",
                   n, o_result, m_result, o_zero, m_zero, o_rd, m_rd, o_pc, m_pc);
        end
      end
    end
    i_rst = 0; i_flush = 0; i_stall = 0;
  endtask

  initial begin
    codes[0] = ADD;  codes[1] = ADDU;  codes[2] = SUB;   codes[3] = SUBU;
    codes[4] = AND_; codes[5] = OR_;   codes[6] = XOR_;  codes[7] = NOR_;
    codes[8] = SLT;  codes[9] = SLTU;  codes[10] = SLL;  codes[11] = SRL;
    codes[12] = SRA; codes[13] = SLLV; codes[14] = SRLV; codes[15] = SRAV;
    codes[16] = LUI; codes[17] = ROTR; codes[18] = ROTRV; codes[19] = 6'b101101;

    i_rst = 1; i_valid = 0; i_aluControl = 0; i_ALUSrc_op1 = 0; i_shamt = 0;
    i_op1 = 0; i_op2 = 0; i_rd = 0; i_reg_write = 0; i_pc = 0; i_stall = 0; i_flush = 0;
    m_valid = 0; m_result = 0; m_zero = 0; m_rd = 0; m_rw = 0; m_pc = 0; m_ovf = 0; m_exc_pc = 0;
    #2;

    test_reset();
    test_arith();
    test_shift();
    test_compare_lui();
    test_stall_flush();
    test_bubble();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
